// File: rtl/mpa_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mpa_pkg;

   // Sequencer states: idle/accepting, stepping through words, holding the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default slice width and operand length in words.
   localparam int unsigned MPA_W     = 16;
   localparam int unsigned MPA_WORDS = 4;

   // Bit offset of word idx inside a packed multi-word operand of w-bit words.
   function automatic int unsigned word_off(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/mpa_add_slice.sv
// W-bit adder a+b+cin built from 4-bit carry-lookahead groups, group carries rippled between groups.
// Latency: combinational.
// Backpressure: none; W must be a multiple of 4.
module mpa_add_slice #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   localparam int unsigned NG = W / 4;

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W-1:0] cb;
   logic         gc;
   logic         acc;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Each carry inside a group is expanded from the group carry-in only, so the
   // in-group carries resolve in parallel; only the group carry-out chains onward.
   always_comb begin
      cb  = '0;
      acc = 1'b0;
      gc  = cin_i;
      for (int gi = 0; gi < NG; gi++) begin
         cb[gi*4] = gc;
         for (int j = 1; j <= 4; j++) begin
            acc = gc;
            for (int k = 0; k < j; k++) begin
               acc = g[gi*4+k] | (p[gi*4+k] & acc);
            end
            if (j < 4) begin
               cb[gi*4+j] = acc;
            end
         end
         gc = acc;
      end
      sum_o  = p ^ cb;
      cout_o = gc;
   end

endmodule

// File: rtl/mpa_sequencer.sv
// Multi-precision adder: WORDS*W-bit A+B+cin through one W-bit slice, one word per cycle, LSW first.
// Latency: out_valid rises WORDS cycles after the accepting edge; one operation in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional macro MPA_SUB_EN adds in_sub (A-B).
module mpa_sequencer
   import mpa_pkg::*;
#(
   parameter int unsigned W     = MPA_W,
   parameter int unsigned WORDS = MPA_WORDS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORDS*W-1:0] in_a,
   input  logic [WORDS*W-1:0] in_b,
`ifdef MPA_SUB_EN
   input  logic               in_sub,
`endif
   input  logic               in_cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORDS*W-1:0] out_sum,
   output logic               out_cout,
   output logic               busy
);

   localparam int unsigned      CW   = $clog2(WORDS);
   localparam logic [CW-1:0]    LAST = CW'(WORDS - 1);

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WORDS*W-1:0] a_q;
   logic [WORDS*W-1:0] b_q;
   logic [WORDS*W-1:0] sum_q;
   logic               carry_q;
   logic               cout_q;
   logic               sub_q;

   logic               sub_in;
   logic [W-1:0]       a_word;
   logic [W-1:0]       b_word;
   logic [W-1:0]       sum_d;
   logic               carry_d;

`ifdef MPA_SUB_EN
   assign sub_in = in_sub;
`else
   assign sub_in = 1'b0;
`endif

   // Select the current word of each operand; subtraction feeds the inverted B word.
   always_comb begin
      a_word = a_q[word_off(32'(cnt_q), W) +: W];
      b_word = b_q[word_off(32'(cnt_q), W) +: W];
      if (sub_q) begin
         b_word = ~b_word;
      end
   end

   mpa_add_slice #(
      .W (W)
   ) u_slice (
      .a_i    (a_word),
      .b_i    (b_word),
      .cin_i  (carry_q),
      .sum_o  (sum_d),
      .cout_o (carry_d)
   );

   // Control FSM plus operand, carry, counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  sub_q   <= sub_in;
                  // Two's-complement subtract: inverted B plus a forced carry of one.
                  carry_q <= sub_in ? 1'b1 : in_cin;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[word_off(32'(cnt_q), W) +: W] <= sum_d;
               carry_q <= carry_d;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  cout_q  <= carry_d;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule
